// File: rtl/mem_responder_pkg.sv
// Shared definitions for the multi-cycle memory responder: FSM state encoding,
// latched operation encoding and the data word width.
package mem_responder_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/mem_resp_array.sv
// Word storage behind mem_responder: synchronous write port, asynchronous read port.
// Contents are deliberately not reset.
module mem_resp_array
    import mem_responder_pkg::*;
#(
    parameter int ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-2:0] waddr,
    input  logic [WORD_W-1:0]    wdata,
    input  logic [ADDR_BITS-2:0] raddr,
    output logic [WORD_W-1:0]    rdata
);

    logic [WORD_W-1:0] mem [2**(ADDR_BITS-1)];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle memory responder: accepts one read or write at a time, completes it
// LATENCY cycles later with a done pulse. Optional macro ALIGN_CHK_EN rejects odd addresses.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int LATENCY   = 4,
    parameter int ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WORD_W-1:0]    data_in,
    input  logic                 rd,
    input  logic                 wr,
    output logic [WORD_W-1:0]    data_out,
    output logic                 done,
    output logic                 stall,
    output logic                 err
);

    localparam int                CNT_W    = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [ADDR_BITS-2:0]   word_reg, word_next;
    logic [WORD_W-1:0]      wdata_reg, wdata_next;
    op_t                    op_reg, op_next;
    logic                   err_reg, err_next;

    logic                   conflict;
    logic                   single;
    logic                   misalign;
    logic                   accept;
    logic                   mem_we;
    logic [WORD_W-1:0]      mem_rdata;

    assign conflict = rd & wr;
    assign single   = rd ^ wr;
`ifdef ALIGN_CHK_EN
    assign misalign = single & addr[0];
`else
    // Byte-lane bit has no effect in this build; odd addresses hit word addr>>1.
    assign misalign = single & addr[0] & 1'b0;
`endif
    assign accept   = single & ~misalign;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        word_next  = word_reg;
        wdata_next = wdata_reg;
        op_next    = op_reg;
        err_next   = 1'b0;
        stall      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (conflict || misalign) begin
                    err_next = 1'b1;
                end else if (accept) begin
                    word_next  = addr[ADDR_BITS-1:1];
                    wdata_next = data_in;
                    op_next    = wr ? OP_WR : OP_RD;
                    cnt_next   = CNT_LOAD;
                    stall      = 1'b1;
                    state_next = (LATENCY == 1) ? DONE : BUSY;
                end
            end
            BUSY: begin
                stall    = 1'b1;
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            word_reg  <= '0;
            wdata_reg <= '0;
            op_reg    <= OP_RD;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            word_reg  <= word_next;
            wdata_reg <= wdata_next;
            op_reg    <= op_next;
            err_reg   <= err_next;
        end
    end

    assign done     = (state_reg == DONE);
    assign err      = err_reg;
    // A reset landing in the done cycle must not let the write commit.
    assign mem_we   = done && (op_reg == OP_WR) && !rst;
    assign data_out = (done && (op_reg == OP_RD)) ? mem_rdata : '0;

    mem_resp_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .waddr(word_reg),
        .wdata(wdata_reg),
        .raddr(word_reg),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: drivers queue expected done/err responses,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int LATENCY = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = '0;
    logic [15:0] data_in = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] data_out;
    logic        done;
    logic        stall;
    logic        err;

    typedef struct {
        bit          is_err;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    int   start_cyc;

    mem_responder #(
        .LATENCY(LATENCY),
        .ADDR_BITS(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .data_in (data_in),
        .rd      (rd),
        .wr      (wr),
        .data_out(data_out),
        .done    (done),
        .stall   (stall),
        .err     (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every done or err pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (done || err) begin
            check(done ? "resp_expected_done" : "resp_expected_err", (q.size() > 0) ? 1 : 0, 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("resp_kind_err", int'(err), int'(e.is_err));
                check("resp_data", int'(data_out), int'(e.data));
                check("resp_cycle", cyc, e.cyc);
                $display("resp cycle %0d: done=%0d err=%0d data_out=0x%04h", cyc, done, err, data_out);
            end
        end
    end

    // Waits for done, checking stall each busy cycle; returns at posedge+1 after done.
    task automatic wait_done();
        bit seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                check("stall_in_done_cycle", int'(stall), 0);
            end else begin
                check("stall_while_busy", int'(stall), 1);
            end
        end
        if (!seen) check("done_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic access(input bit is_wr, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] exp_rd);
        exp_t x;
        addr    = a;
        data_in = d;
        rd      = !is_wr;
        wr      = is_wr;
        x.is_err = 1'b0;
        x.data   = is_wr ? 16'h0000 : exp_rd;
        x.cyc    = cyc + LATENCY;
        q.push_back(x);
        wait_done();
        rd = 1'b0;
        wr = 1'b0;
    endtask

    task automatic expect_err_request(input logic [15:0] a, input bit both);
        exp_t x;
        addr = a;
        rd   = 1'b1;
        wr   = both;
        x.is_err = 1'b1;
        x.data   = 16'h0000;
        x.cyc    = cyc + 1;
        q.push_back(x);
        @(negedge clk);
        check("stall_on_rejected", int'(stall), 0);
        @(posedge clk);
        #1;
        rd = 1'b0;
        wr = 1'b0;
        @(negedge clk);
        check("no_done_on_rejected", int'(done), 0);
        @(negedge clk);
        check("err_single_pulse", int'(err), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_done", int'(done), 0);
        check("reset_stall", int'(stall), 0);
        check("reset_err", int'(err), 0);
        check("reset_data_out", int'(data_out), 0);
        @(posedge clk);
        #1;

        // Preload through the write path.
        access(1'b1, 16'h0020, 16'hBEEF, 16'h0);
        access(1'b1, 16'h0002, 16'h1111, 16'h0);
        access(1'b1, 16'h0004, 16'h2222, 16'h0);

        // Basic read latency, data_out returns to zero after done.
        access(1'b0, 16'h0020, 16'h0, 16'hBEEF);
        @(negedge clk);
        check("data_out_after_done", int'(data_out), 0);
        check("done_after_done", int'(done), 0);
        @(posedge clk);
        #1;

        // Back-to-back write then read: 10 cycles in total.
        start_cyc = cyc;
        access(1'b1, 16'h0040, 16'h1234, 16'h0);
        access(1'b0, 16'h0040, 16'h0, 16'h1234);
        check("b2b_total_cycles", cyc - start_cyc, 10);

        // Simultaneous rd&wr is rejected and nothing is written.
        data_in = 16'h9999;
        expect_err_request(16'h0002, 1'b1);
        access(1'b0, 16'h0002, 16'h0, 16'h1111);

        // Request changed while busy is ignored.
        begin
            exp_t x;
            addr = 16'h0002;
            rd   = 1'b1;
            wr   = 1'b0;
            x.is_err = 1'b0;
            x.data   = 16'h1111;
            x.cyc    = cyc + LATENCY;
            q.push_back(x);
            @(posedge clk);
            #1;
            rd      = 1'b0;
            wr      = 1'b1;
            addr    = 16'h0004;
            data_in = 16'hDEAD;
            wait_done();
            rd = 1'b0;
            wr = 1'b0;
        end
        access(1'b0, 16'h0004, 16'h0, 16'h2222);

        // Reset in the middle of a write aborts it.
        access(1'b1, 16'h0006, 16'h5555, 16'h0);
        addr    = 16'h0006;
        data_in = 16'hAAAA;
        wr      = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        wr  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("stall_after_abort", int'(stall), 0);
        check("done_after_abort", int'(done), 0);
        repeat (4) @(posedge clk);
        #1;
        access(1'b0, 16'h0006, 16'h0, 16'h5555);

        // Odd address handling.
`ifdef ALIGN_CHK_EN
        expect_err_request(16'h0003, 1'b0);
`else
        access(1'b0, 16'h0003, 16'h0, 16'h1111);
`endif

        // Top word of the array and word 0 are distinct locations.
        access(1'b1, 16'hFFFE, 16'h7777, 16'h0);
        access(1'b1, 16'h0000, 16'h0101, 16'h0);
        access(1'b0, 16'hFFFE, 16'h0, 16'h7777);
        access(1'b0, 16'h0000, 16'h0, 16'h0101);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d expected under 20000", cyc);
        $fatal(1);
    end

endmodule
